// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared definitions for the fetch/branch stage: default widths, flow-control
//   opcodes (top nibble of an instruction) and the fetch FSM state encoding.
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned OP_W    = 4;

    // Flow-control opcodes; every other opcode is passed through to execute.
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;
    localparam logic [OP_W-1:0] OP_JMP  = 4'hE;
    localparam logic [OP_W-1:0] OP_JZ   = 4'hD;
    localparam logic [OP_W-1:0] OP_CALL = 4'hC;
    localparam logic [OP_W-1:0] OP_RET  = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// ---------------------------------------------------------------------------
// instr_fetch_prog_mem
//   Program store: (1 << ADDR_W) x DATA_W words, one synchronous write port and
//   one registered read port. The read register is the fetch stage's ir and is
//   cleared by reset; the array contents are not.
// Ports
//   clk, rstn   clock, asynchronous active-low reset (read register only)
//   we/waddr/wdata  write port
//   raddr       read address (the counter's current PC)
//   rdata       registered read data, mem[raddr] of the previous cycle
// ---------------------------------------------------------------------------
module instr_fetch_prog_mem #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Storage array: no reset, written only when the owner allows it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = mem_q[raddr];
    end

    // Read register; a same-cycle write is seen on the following read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Fetch/branch stage wrapped around a free-running program counter. Reads the
//   program store at cnt, decodes flow-control opcodes one cycle later and
//   requests counter loads; all other instructions go to execute.
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   run                  start pulse (honoured in IDLE/HALT)
//   cnt, cnt_store       counter PC and its captured return address
//   zero_flag            execute-stage zero flag, used only by JZ decode
//   prog_we/waddr/wdata  program write port (honoured in IDLE/HALT)
//   cnt_load, cnt_val    one-cycle counter load request and target
//   instr_out, instr_valid  instruction to execute and its valid
//   halted               high while in HALT
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned       INSTR_W    = instr_fetch_pkg::INSTR_W,
    parameter int unsigned       ADDR_W     = instr_fetch_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               run,
    input  logic [ADDR_W-1:0]  cnt,
    input  logic [ADDR_W-1:0]  cnt_store,
    input  logic               zero_flag,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_waddr,
    input  logic [INSTR_W-1:0] prog_wdata,
    output logic               cnt_load,
    output logic [ADDR_W-1:0]  cnt_val,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic               halted
);

    import instr_fetch_pkg::OP_W;
    import instr_fetch_pkg::OP_HALT;
    import instr_fetch_pkg::OP_JMP;
    import instr_fetch_pkg::OP_JZ;
    import instr_fetch_pkg::OP_CALL;
    import instr_fetch_pkg::OP_RET;
    import instr_fetch_pkg::state_e;
    import instr_fetch_pkg::ST_IDLE;
    import instr_fetch_pkg::ST_RUN;
    import instr_fetch_pkg::ST_FLUSH;
    import instr_fetch_pkg::ST_HALT;

    state_e             state_q;
    state_e             state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [OP_W-1:0]    opcode;
    logic [ADDR_W-1:0]  target;
    logic               prog_open;
    logic               mem_we;

    // Program may only change while nothing is being fetched for execution.
    assign prog_open = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign mem_we    = prog_we && prog_open;

    instr_fetch_prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (INSTR_W)
    ) u_prog_mem (
        .clk   (clk),
        .rstn  (rstn),
        .we    (mem_we),
        .waddr (prog_waddr),
        .wdata (prog_wdata),
        .raddr (cnt),
        .rdata (ir_q)
    );

    assign opcode = ir_q[INSTR_W-1 -: OP_W];
    assign target = ir_q[ADDR_W-1:0];

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and decode. Every load is followed by one FLUSH cycle because
    // the word already in ir was fetched from the pre-load address.
    always_comb begin
        state_d     = state_q;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        instr_out   = '0;
        instr_valid = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (run) begin
                    cnt_load = 1'b1;
                    cnt_val  = START_ADDR;
                    state_d  = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                case (opcode)
                    OP_HALT: begin
                        state_d = ST_HALT;
                    end
                    OP_JMP, OP_CALL: begin
                        cnt_load = 1'b1;
                        cnt_val  = target;
                        state_d  = ST_FLUSH;
                    end
                    OP_JZ: begin
                        // Untaken JZ is a bubble; the counter already points past it.
                        if (zero_flag) begin
                            cnt_load = 1'b1;
                            cnt_val  = target;
                            state_d  = ST_FLUSH;
                        end
                    end
                    OP_RET: begin
                        cnt_load = 1'b1;
                        cnt_val  = cnt_store;
                        state_d  = ST_FLUSH;
                    end
                    default: begin
                        instr_out   = ir_q;
                        instr_valid = 1'b1;
                    end
                endcase
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign halted = (state_q == ST_HALT);

endmodule
